// File: rtl/fifo_stream_drain_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_drain_if
// Description : Bundles the FIFO read port (rd_en/data_out/empty) and the
//               valid/ready output stream of fifo_stream_drain.
//               master : drain side (issues reads, drives the stream)
//               slave  : environment side (FIFO + downstream consumer)
// Revision    : 1.0  initial release
// ============================================================================
interface fifo_stream_drain_if #(
  parameter int FIFO_WIDTH = 16
) ();
  logic                  fifo_empty;
  logic [FIFO_WIDTH-1:0] fifo_data_out;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    input  fifo_empty, fifo_data_out, m_ready,
    output fifo_rd_en, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_data_out, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_last
  );
endinterface
`default_nettype wire

// File: rtl/fifo_stream_drain.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_drain
// Description : Drains a 1-cycle-latency synchronous FIFO into a valid/ready
//               stream through a 2-entry skid buffer, frames the stream into
//               PKT_LEN-word packets (m_last) and counts completed packets.
// Ports       : clk       - clock, rising edge
//               rst_n     - asynchronous active-low reset
//               bus       - FIFO read port + output stream (master modport)
//               pkt_count - completed packet count, wraps at 2^CNT_WIDTH
// Revision    : 1.0  initial release
// ============================================================================
module fifo_stream_drain #(
  parameter int FIFO_WIDTH = 16,
  parameter int PKT_LEN    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_stream_drain_if.master  bus,
  output logic [CNT_WIDTH-1:0] pkt_count
);

  localparam int                  c_BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(PKT_LEN - 1);

  logic [1:0]            r_cnt;         // skid buffer occupancy, 0..2
  logic                  r_rd_pending;  // FIFO read issued last cycle
  logic [FIFO_WIDTH-1:0] r_buf0;        // head entry
  logic [FIFO_WIDTH-1:0] r_buf1;        // tail entry
  logic [c_BEAT_W-1:0]   r_beat;
  logic [CNT_WIDTH-1:0]  r_pkt_count;

  logic       w_valid;
  logic       w_last;
  logic       w_pop;
  logic       w_push;
  logic [2:0] w_level;
  logic       w_rd_en;
  logic [1:0] w_cnt_next;
  logic       w_wr_tail;

  assign w_valid = (r_cnt != 2'd0);
  assign w_last  = w_valid && (r_beat == c_LAST_BEAT);
  assign w_pop   = w_valid && bus.m_ready;
  assign w_push  = r_rd_pending;

  // Occupancy committed after this edge, counting the read already in
  // flight. A pop implies r_cnt >= 1, so the subtraction cannot underflow.
  assign w_level = {1'b0, r_cnt} + {2'b00, r_rd_pending} - {2'b00, w_pop};
  assign w_rd_en = !bus.fifo_empty && (w_level < 3'd2);

  assign w_cnt_next = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

  // An arriving word lands in the tail slot only when one word remains in
  // the buffer after this edge's pop; otherwise it becomes the new head.
  assign w_wr_tail = (r_cnt == 2'd2) || ((r_cnt == 2'd1) && !w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= 2'd0;
      r_rd_pending <= 1'b0;
      r_buf0       <= '0;
      r_buf1       <= '0;
      r_beat       <= '0;
      r_pkt_count  <= '0;
    end else begin
      r_rd_pending <= w_rd_en;
      r_cnt        <= w_cnt_next;

      if (w_pop) begin
        r_buf0 <= r_buf1;
      end
      // Placed after the shift so a simultaneous push into the head slot wins.
      if (w_push) begin
        if (w_wr_tail) begin
          r_buf1 <= bus.fifo_data_out;
        end else begin
          r_buf0 <= bus.fifo_data_out;
        end
      end

      if (w_pop) begin
        r_beat <= w_last ? '0 : r_beat + 1'b1;
        if (w_last) begin
          r_pkt_count <= r_pkt_count + 1'b1;
        end
      end
    end
  end

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_valid    = w_valid;
  assign bus.m_data     = r_buf0;
  assign bus.m_last     = w_last;
  assign pkt_count      = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_stream_drain
// Description : Directed self-checking bench for fifo_stream_drain. Contains
//               a behavioural 1-cycle-latency FIFO and a word scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_stream_drain;

  localparam int c_W   = 16;
  localparam int c_PKT = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] pkt_count;

  fifo_stream_drain_if #(.FIFO_WIDTH(c_W)) bus ();

  fifo_stream_drain #(
    .FIFO_WIDTH(c_W),
    .PKT_LEN   (c_PKT),
    .CNT_WIDTH (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .pkt_count(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: data_out valid the cycle after an accepted rd_en.
  logic [15:0] fmem [0:255];
  logic [7:0]  wp;
  logic [7:0]  rp;
  logic        wr_en;
  logic [15:0] wr_data;

  assign bus.fifo_empty = (wp == rp);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp                <= 8'd0;
      rp                <= 8'd0;
      bus.fifo_data_out <= 16'd0;
    end else begin
      if (wr_en) begin
        fmem[wp] <= wr_data;
        wp       <= wp + 8'd1;
      end
      if (bus.fifo_rd_en && !bus.fifo_empty) begin
        bus.fifo_data_out <= fmem[rp];
        rp                <= rp + 8'd1;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] wq[$];     // words waiting to be written into the FIFO
  logic [15:0] exp_q[$];  // words written, not yet seen leaving the stream
  int          wr_pct;
  int          rdy_mode;  // 0: ready low, 1: ready high, 2: random
  int          ref_beat;
  int          cyc;
  int          first_rd, first_val, first_pop, last_pop, npop;
  logic        prev_stall;
  logic [15:0] prev_data;
  logic        prev_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_marks();
    first_rd  = -1;
    first_val = -1;
    first_pop = -1;
    last_pop  = -1;
    npop      = 0;
  endtask

  // One cycle: drive at the negedge, observe 1 ns later. A word seen with
  // valid & ready here is consumed at the following rising edge.
  task automatic step();
    logic [15:0] e;
    @(negedge clk);
    cyc++;
    if (wq.size() != 0 && (wr_pct >= 100 || $urandom_range(99) < wr_pct)) begin
      wr_en   = 1'b1;
      wr_data = wq.pop_front();
      exp_q.push_back(wr_data);
    end else begin
      wr_en = 1'b0;
    end
    case (rdy_mode)
      0:       bus.m_ready = 1'b0;
      1:       bus.m_ready = 1'b1;
      default: bus.m_ready = 1'($urandom_range(1));
    endcase
    #1;
    if (prev_stall) begin
      chk("hold_valid", {31'd0, bus.m_valid}, 32'd1);
      chk("hold_data",  {16'd0, bus.m_data}, {16'd0, prev_data});
      chk("hold_last",  {31'd0, bus.m_last}, {31'd0, prev_last});
    end
    chk("cnt_le_2", {31'd0, (dut.r_cnt <= 2'd2)}, 32'd1);
    if (bus.fifo_empty) chk("rd_en_while_empty", {31'd0, bus.fifo_rd_en}, 32'd0);
    if (!bus.m_valid)   chk("last_without_valid", {31'd0, bus.m_last}, 32'd0);
    if (bus.fifo_rd_en && first_rd < 0) first_rd = cyc;
    if (bus.m_valid && first_val < 0)   first_val = cyc;
    if (bus.m_valid && bus.m_ready) begin
      chk("word_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("m_data", {16'd0, bus.m_data}, {16'd0, e});
        chk("m_last", {31'd0, bus.m_last}, {31'd0, (ref_beat == c_PKT - 1)});
        ref_beat = (ref_beat == c_PKT - 1) ? 0 : ref_beat + 1;
      end
      npop++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    prev_stall = bus.m_valid && !bus.m_ready;
    prev_data  = bus.m_data;
    prev_last  = bus.m_last;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((wq.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_budget", {31'd0, (n < budget)}, 32'd1);
    repeat (4) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.m_valid},    32'd0);
    chk({tag, "_last"},  {31'd0, bus.m_last},     32'd0);
    chk({tag, "_data"},  {16'd0, bus.m_data},     32'd0);
    chk({tag, "_rd_en"}, {31'd0, bus.fifo_rd_en}, 32'd0);
    chk({tag, "_pkts"},  {16'd0, pkt_count},      32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    wr_en       = 1'b0;
    wr_data     = 16'd0;
    bus.m_ready = 1'b0;
    wr_pct      = 100;
    rdy_mode    = 1;
    ref_beat    = 0;
    cyc         = 0;
    prev_stall  = 1'b0;
    prev_data   = 16'd0;
    prev_last   = 1'b0;
    clear_marks();

    // 1. Reset then idle
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) step();
    chk("idle_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("idle_never_rd", first_rd, -1);

    // 2. Streaming 0x0001..0x0008 with ready held high
    clear_marks();
    for (int i = 1; i <= 8; i++) wq.push_back(16'(i));
    drain(200);
    chk("s2_latency", first_val - first_rd, 32'd2);
    chk("s2_back_to_back", last_pop - first_pop, 32'd7);
    chk("s2_npop", npop, 32'd8);
    chk("s2_pkts", {16'd0, pkt_count}, 32'd2);

    // 3. Backpressure: 8 words with ready low for the whole load + 10 cycles
    clear_marks();
    rdy_mode = 0;
    for (int i = 1; i <= 8; i++) wq.push_back(16'(i));
    repeat (18) step();
    chk("bp_valid", {31'd0, bus.m_valid},   32'd1);
    chk("bp_data",  {16'd0, bus.m_data},    32'h0001);
    chk("bp_cnt",   {30'd0, dut.r_cnt},     32'd2);
    chk("bp_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    rdy_mode = 1;
    drain(200);
    chk("bp_npop", npop, 32'd8);
    chk("bp_pkts", {16'd0, pkt_count}, 32'd4);

    // 4. Random ready and random writes, 200 words
    clear_marks();
    rdy_mode = 2;
    wr_pct   = 50;
    for (int i = 0; i < 200; i++) wq.push_back(16'($urandom_range(65535)));
    drain(5000);
    chk("rnd_npop", npop, 32'd200);
    chk("rnd_pkts", {16'd0, pkt_count}, 32'd54);

    // 5. FIFO runs empty mid-packet
    clear_marks();
    rdy_mode = 1;
    wr_pct   = 100;
    for (int i = 0; i < 6; i++) wq.push_back(16'h0051 + 16'(i));
    drain(200);
    chk("part_npop", npop, 32'd6);
    chk("part_pkts", {16'd0, pkt_count}, 32'd55);
    wq.push_back(16'h0057);
    wq.push_back(16'h0058);
    drain(200);
    chk("part2_pkts", {16'd0, pkt_count}, 32'd56);

    // 6. Reset mid-packet after 2 pops with a read in flight
    clear_marks();
    for (int i = 0; i < 4; i++) wq.push_back(16'h0091 + 16'(i));
    for (int n = 0; n < 50 && npop < 2; n++) step();
    chk("mid_two_pops", npop, 32'd2);
    @(posedge clk);
    #2;
    wr_en = 1'b0;
    chk("mid_inflight", {31'd0, dut.r_rd_pending}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    wq.delete();
    exp_q.delete();
    ref_beat   = 0;
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_marks();
    for (int i = 0; i < 4; i++) wq.push_back(16'h00A0 + 16'(i));
    drain(200);
    chk("post_npop", npop, 32'd4);
    chk("post_pkts", {16'd0, pkt_count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_stream_drain.md
Name: fifo_stream_drain

Overview:
- Read-side consumer stage placed directly downstream of the team's synchronous FIFO.
- Pulls words from the FIFO's rd_en/data_out/empty port, which has 1-cycle read latency, and presents them on a valid/ready stream through a 2-entry skid buffer.
- Frames the stream into fixed-length packets with m_last and counts completed packets.
- Sustains 1 word/cycle when the FIFO is non-empty and m_ready is held high.

Parameters:
- FIFO_WIDTH, 16: data width; must match the upstream FIFO.
- PKT_LEN, 4: words per packet, >= 1.
- CNT_WIDTH, 16: width of the packet counter.

Ports:
- clk, input, 1: clock; all state is updated on the rising edge.
- rst_n, input, 1: asynchronous active-low reset; shared with the FIFO.
- fifo_empty, input, 1: FIFO empty flag.
- fifo_data_out, input, FIFO_WIDTH: FIFO read data; valid the cycle after an accepted rd_en.
- fifo_rd_en, output, 1: FIFO read request.
- m_valid, output, 1: stream word valid.
- m_ready, input, 1: downstream accepts the word.
- m_data, output, FIFO_WIDTH: stream data.
- m_last, output, 1: current word is the final word of its packet.
- pkt_count, output, CNT_WIDTH: number of completed packets; wraps at 2^CNT_WIDTH.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - Skid buffer occupancy cnt=0, rd_pending=0, beat=0, pkt_count=0.
  - Outputs: m_valid=0, m_last=0, m_data=0, fifo_rd_en=0.
  - A read in flight at reset is discarded and never presented.
- Definitions:
  - pop = m_valid & m_ready.
  - push = rd_pending, registered.
- Read issue is combinational: fifo_rd_en = !fifo_empty & (cnt + rd_pending - pop < 2).
  - m_ready → fifo_rd_en is a combinational path.
  - fifo_rd_en is never asserted while fifo_empty=1.
- rd_pending <= fifo_rd_en on every edge. When rd_pending=1, fifo_data_out is written into the skid buffer at that edge.
- Skid buffer is a 2-entry in-order queue:
  - cnt_next = cnt + push - pop, always in the range 0..2.
  - Overflow is impossible by construction; the verifier asserts it.
  - Simultaneous push and pop with cnt=1 leaves cnt=1; the new word becomes head next cycle.
- Output side:
  - m_valid = (cnt != 0); m_data = head entry. Both are registered outputs.
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable.
  - m_valid does not drop without a pop.
- Framing:
  - m_last = m_valid & (beat == PKT_LEN-1).
  - On pop, beat increments; it wraps to 0 after PKT_LEN-1.
  - PKT_LEN=1 gives m_last on every valid word.
- Counting:
  - pkt_count increments on pop & m_last, modulo 2^CNT_WIDTH.
  - Only completed packets count; a partial packet in progress is not counted.
- Latency:
  - From the edge where rd_en is sampled with FIFO non-empty to m_valid=1 is 2 edges: edge 1 loads FIFO data_out, edge 2 pushes into the buffer.
  - Minimum latency from empty→non-empty to the first m_valid is 2 cycles after fifo_rd_en.
- Backpressure: when m_ready=0 for long enough, the buffer holds 2 words, fifo_rd_en=0, and no data is lost.
- Reset mid-packet: beat returns to 0, so the next packet starts fresh. The verifier must reset the FIFO and the drain together.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles, FIFO empty → all outputs 0, fifo_rd_en never 1 for 20 cycles.
2. Streaming: write 0x0001..0x0008 into the FIFO, m_ready=1 → m_data 0x0001..0x0008 in order on consecutive cycles, m_last on 0x0004 and 0x0008, pkt_count=2.
3. Backpressure: 8 words loaded, m_ready=0 for 10 cycles → m_valid=1 with m_data=0x0001 held stable, cnt=2, fifo_rd_en=0. Then m_ready=1 → all 8 words delivered, none lost or duplicated.
4. Random m_ready (50%) with concurrent random FIFO writes of 200 words → the output sequence matches the scoreboard, m_last is every 4th word, pkt_count=50, and the cnt<=2 assertion never fires.
5. FIFO runs empty mid-packet: 6 words written → 6 words out, m_last only on word 4, pkt_count=1. Then write 2 more words → m_last on word 8, pkt_count=2.
6. Reset asserted mid-packet after 2 pops with a read in flight → outputs 0 immediately. After release, new words 0x00A0..0x00A3 yield m_last on 0x00A3 and pkt_count=1.
